fifo_uart_tx: RTL and testbench
===============================

Name: fifo_uart_tx

Overview:
Downstream stage of the status-message FIFO. It pops bytes from a standard (non-FWFT) FIFO with a 1-cycle read latency and serialises each one as an 8N1 frame (8 data bits, no parity, 1 stop bit by default) on the UART TX line toward the host terminal. It runs on the system clock and generates its own baud timing with a clock-divider counter. It accepts back-to-back bytes.

Parameters:
CLKS_PER_BIT, 5208, system clock cycles per UART bit (50 MHz / 9600 baud); legal values are 2 or more.
STOP_BITS, 1, number of stop bits per frame; legal values are 1 or 2.

Ports:
clk  input  1  system clock; all logic is on the rising edge.
rst  input  1  synchronous, active-high reset.
fifoEmpty  input  1  FIFO empty flag.
fifoDout  input  8  FIFO read data; valid the cycle after fifoRdEn.
fifoRdEn  output  1  FIFO read strobe; one-cycle pulse per byte.
txData  output  1  UART TX line; idles high.
busy  output  1  high whenever the state is not IDLE.
frameDone  output  1  one-cycle pulse on the last cycle of the final stop bit.

Behaviour:
- Reset (rst sampled high at a clk edge):
  - state = IDLE; txData = 1; fifoRdEn = 0; busy = 0; frameDone = 0.
  - Baud counter, bit index and shift register are cleared.
  - Reset mid-frame aborts the frame. txData is 1 from the next cycle and the popped byte is lost; no frameDone is issued.
- States: IDLE, LATCH, START, DATA, STOP.
- IDLE:
  - txData = 1.
  - If fifoEmpty = 0, drive fifoRdEn = 1 for this single cycle and go to LATCH.
  - Otherwise stay in IDLE with fifoRdEn = 0.
  - fifoRdEn is never asserted outside IDLE and never while fifoEmpty = 1.
- LATCH (1 cycle):
  - Capture fifoDout into the 8-bit shift register.
  - txData = 1; clear the baud counter; go to START.
- START: txData = 0 for exactly CLKS_PER_BIT cycles, then go to DATA with bit index = 0.
- DATA:
  - txData = shift register bit 0 (LSB first).
  - Each bit is held CLKS_PER_BIT cycles; at the end of each bit, shift right and increment the index.
  - After bit 7 completes, go to STOP.
- STOP:
  - txData = 1 for STOP_BITS*CLKS_PER_BIT cycles.
  - frameDone = 1 on the last cycle only; then go to IDLE.
- Baud counter:
  - Width is clog2(CLKS_PER_BIT) bits (clog2(2*CLKS_PER_BIT) when STOP_BITS = 2).
  - Counts 0 .. N-1, and a bit ends when the counter reaches N-1.
  - The counter wraps to 0 at every bit boundary, so no drift accumulates across bits.
- Timing:
  - Latency from the IDLE cycle with fifoRdEn high to the falling edge of the start bit: 2 cycles.
  - Frame length, start-bit falling edge to stop-bit end: (9+STOP_BITS)*CLKS_PER_BIT cycles.
  - Back-to-back bytes have a start-edge spacing of (9+STOP_BITS)*CLKS_PER_BIT + 2 cycles, with txData high during the 2 gap cycles.
- fifoEmpty is ignored outside IDLE. Bytes written to the FIFO during a frame are sent afterwards, in order.
- busy is a registered function of state (high in LATCH/START/DATA/STOP) with no combinational path from inputs to any output.

Test Plan:
1. Reset: hold rst for 3 cycles with fifoEmpty = 1 -> txData = 1, fifoRdEn = 0, busy = 0 and frameDone = 0, stable for 100 cycles.
2. Single byte 0x55 (CLKS_PER_BIT = 4):
   - Expect exactly one fifoRdEn pulse.
   - Expect txData low 2 cycles after the pulse.
   - Expect bits 1,0,1,0,1,0,1,0 at 4 cycles each, then high.
   - Expect frameDone at start-edge + 39 cycles.
3. Back-to-back 0x00, 0xFF, 0xA5:
   - Expect three fifoRdEn pulses with start edges 42 cycles apart.
   - A decoded receiver model reads 0x00, 0xFF, 0xA5.
4. STOP_BITS = 2, byte 0x80:
   - Expect data LSB first (7 zeros, then a 1).
   - Expect stop high for 8 cycles, frame length 44 cycles, and frameDone on cycle 44.
5. Reset mid-frame: assert rst during DATA bit 3 of 0x3C -> txData = 1 next cycle and no frameDone. The next FIFO byte 0x81 is then sent intact.
6. Empty handling: toggle fifoEmpty high during a frame and keep it high after -> fifoRdEn is never asserted while empty, and the FSM idles with busy = 0.

Source files
------------

// File: rtl/fifo_uart_tx_if.sv
// rtl/fifo_uart_tx_if.sv - FIFO read-port bundle between the status FIFO and the UART transmitter
//   fifoEmpty : FIFO empty flag (FIFO -> reader)
//   fifoDout  : FIFO read data, valid the cycle after fifoRdEn (FIFO -> reader)
//   fifoRdEn  : one-cycle read strobe per byte (reader -> FIFO)
//   master    : FIFO side, slave : transmitter side
interface fifo_uart_tx_if;
  logic       fifoEmpty;
  logic [7:0] fifoDout;
  logic       fifoRdEn;

  modport master (output fifoEmpty, output fifoDout, input fifoRdEn);
  modport slave  (input fifoEmpty, input fifoDout, output fifoRdEn);
endinterface

// File: rtl/fifo_uart_tx.sv
// rtl/fifo_uart_tx.sv - pops bytes from a 1-cycle-latency FIFO and sends them as 8N1/8N2 UART frames
//   clk       : system clock, rising edge
//   rst       : synchronous active-high reset
//   fifo      : FIFO read port (slave modport: fifoEmpty, fifoDout in; fifoRdEn out)
//   txData    : UART TX line, idles high
//   busy      : high while a byte is being latched or transmitted
//   frameDone : one-cycle pulse on the last cycle of the final stop bit
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int STOP_BITS    = 1
) (
  input  logic          clk,
  input  logic          rst,
  fifo_uart_tx_if.slave fifo,
  output logic          txData,
  output logic          busy,
  output logic          frameDone
);

  localparam int STOP_CLKS = STOP_BITS * CLKS_PER_BIT;
  // The stop phase is timed as one long bit, so the counter must reach STOP_CLKS-1.
  localparam int CNT_W = $clog2((STOP_BITS == 2) ? 2 * CLKS_PER_BIT : CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_CLKS - 1);

  typedef enum logic [2:0] {IDLE, LATCH, START, DATA, STOP} state_t;

  state_t           state, stateNext;
  logic [CNT_W-1:0] baudCnt, baudCntNext;
  logic [2:0]       bitIdx, bitIdxNext;
  logic [7:0]       shiftReg, shiftRegNext;
  logic             rdEn, rdEnNext;
  logic             txNext, busyNext, doneNext;

  assign fifo.fifoRdEn = rdEn;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      baudCnt   <= '0;
      bitIdx    <= '0;
      shiftReg  <= '0;
      rdEn      <= 1'b0;
      txData    <= 1'b1;
      busy      <= 1'b0;
      frameDone <= 1'b0;
    end else begin
      state     <= stateNext;
      baudCnt   <= baudCntNext;
      bitIdx    <= bitIdxNext;
      shiftReg  <= shiftRegNext;
      rdEn      <= rdEnNext;
      txData    <= txNext;
      busy      <= busyNext;
      frameDone <= doneNext;
    end
  end

  always_comb begin
    stateNext    = state;
    baudCntNext  = baudCnt;
    bitIdxNext   = bitIdx;
    shiftRegNext = shiftReg;

    case (state)
      // The read strobe is the IDLE cycle that hands off to LATCH.
      IDLE: if (rdEn) stateNext = LATCH;
      LATCH: begin
        shiftRegNext = fifo.fifoDout;
        baudCntNext  = '0;
        stateNext    = START;
      end
      START: begin
        if (baudCnt == BIT_LAST) begin
          baudCntNext = '0;
          bitIdxNext  = '0;
          stateNext   = DATA;
        end else begin
          baudCntNext = baudCnt + 1'b1;
        end
      end
      DATA: begin
        if (baudCnt == BIT_LAST) begin
          baudCntNext  = '0;
          shiftRegNext = {1'b0, shiftReg[7:1]};
          bitIdxNext   = bitIdx + 3'd1;
          if (bitIdx == 3'd7) stateNext = STOP;
        end else begin
          baudCntNext = baudCnt + 1'b1;
        end
      end
      STOP: begin
        if (baudCnt == STOP_LAST) begin
          baudCntNext = '0;
          stateNext   = IDLE;
        end else begin
          baudCntNext = baudCnt + 1'b1;
        end
      end
      default: stateNext = IDLE;
    endcase

    // All outputs are registered from the next-cycle view, so they line up with
    // the state they describe without any input-to-output combinational path.
    // Looking ahead at stateNext lets the strobe land in the first IDLE cycle
    // after a frame, keeping back-to-back frames two cycles apart.
    rdEnNext = (stateNext == IDLE) && !fifo.fifoEmpty;
    busyNext = (stateNext != IDLE);
    doneNext = (stateNext == STOP) && (baudCntNext == STOP_LAST);
    txNext   = 1'b1;
    if (stateNext == START)     txNext = 1'b0;
    else if (stateNext == DATA) txNext = shiftRegNext[0];
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb/tb_fifo_uart_tx.sv - randomized self-checking bench for fifo_uart_tx with a UART line decoder model
module tb_fifo_uart_tx;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fifo_uart_tx_if fa();
  fifo_uart_tx_if fb();
  logic txA, busyA, doneA, txB, busyB, doneB;

  fifo_uart_tx #(.CLKS_PER_BIT(N), .STOP_BITS(1)) dutA (
    .clk(clk), .rst(rst), .fifo(fa.slave), .txData(txA), .busy(busyA), .frameDone(doneA));
  fifo_uart_tx #(.CLKS_PER_BIT(N), .STOP_BITS(2)) dutB (
    .clk(clk), .rst(rst), .fifo(fb.slave), .txData(txB), .busy(busyB), .frameDone(doneB));

  int         vectors = 0;
  int         miscompares = 0;
  int         cyc = 0;
  int         badRd = 0;
  logic       forceA = 1'b0;
  logic       txLog[2][$];
  int         rdCyc[2][$];
  int         doneCyc[2][$];
  logic [7:0] fifoQ[2][$];
  logic [7:0] expQ[2][$];
  int         startQ[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // FIFO models (1-cycle read latency) and line/event logging, on the falling edge.
  always @(negedge clk) begin
    txLog[0].push_back(txA);
    txLog[1].push_back(txB);
    if (doneA) doneCyc[0].push_back(cyc);
    if (doneB) doneCyc[1].push_back(cyc);
    if (fa.fifoRdEn === 1'b1) begin
      rdCyc[0].push_back(cyc);
      if (fa.fifoEmpty) badRd++;
      if (fifoQ[0].size() > 0) fa.fifoDout = fifoQ[0].pop_front();
    end
    if (fb.fifoRdEn === 1'b1) begin
      rdCyc[1].push_back(cyc);
      if (fb.fifoEmpty) badRd++;
      if (fifoQ[1].size() > 0) fb.fifoDout = fifoQ[1].pop_front();
    end
    fa.fifoEmpty = (fifoQ[0].size() == 0) || forceA;
    fb.fifoEmpty = (fifoQ[1].size() == 0);
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input int k, input logic [7:0] b);
    fifoQ[k].push_back(b);
    expQ[k].push_back(b);
  endtask

  task automatic clearLogs();
    for (int k = 0; k < 2; k++) begin
      rdCyc[k].delete();
      doneCyc[k].delete();
      expQ[k].delete();
    end
    startQ.delete();
  endtask

  task automatic waitIdle(input string tag);
    int t;
    t = 0;
    do begin
      tick();
      t++;
    end while ((busyA || busyB || fa.fifoRdEn || fb.fifoRdEn ||
                fifoQ[0].size() > 0 || fifoQ[1].size() > 0) && t < 5000);
    if (t >= 5000) check({tag, "_timeout"}, t, 0);
    repeat (4) tick();
  endtask

  // Decode the logged line from cycle 'from' as a UART receiver and compare
  // every frame against the expected bytes and event timing.
  task automatic analyze(input int k, input int s, input int from, input string tag);
    int frame, n, i, badWave, lastStart;
    logic [7:0] got, e;
    logic w;
    frame = (9 + s) * N;
    n = 0;
    i = from + 1;
    badWave = 0;
    lastStart = 0;
    startQ.delete();
    while (i + frame <= txLog[k].size()) begin
      if (txLog[k][i-1] === 1'b1 && txLog[k][i] === 1'b0) begin
        e = (n < expQ[k].size()) ? expQ[k][n] : 8'h00;
        for (int b = 0; b < 8; b++) got[b] = txLog[k][i + N*(b+1) + N/2];
        check($sformatf("%s_byte%0d", tag, n), got, e);
        for (int o = 0; o < frame; o++) begin
          if (o < N) w = 1'b0;
          else if (o < 9*N) w = e[o/N - 1];
          else w = 1'b1;
          if (txLog[k][i+o] !== w) badWave++;
        end
        if (n < rdCyc[k].size()) check($sformatf("%s_lat%0d", tag, n), i - rdCyc[k][n], 2);
        else check($sformatf("%s_rdmissing%0d", tag, n), rdCyc[k].size(), n + 1);
        if (n < doneCyc[k].size()) check($sformatf("%s_done%0d", tag, n), doneCyc[k][n] - i, frame - 1);
        else check($sformatf("%s_donemissing%0d", tag, n), doneCyc[k].size(), n + 1);
        if (n > 0) check($sformatf("%s_gap%0d", tag, n), (i - lastStart) >= frame + 2, 1);
        startQ.push_back(i);
        lastStart = i;
        n++;
        i += frame;
      end else begin
        i++;
      end
    end
    check({tag, "_frames"}, n, expQ[k].size());
    check({tag, "_rdcount"}, rdCyc[k].size(), n);
    check({tag, "_donecount"}, doneCyc[k].size(), n);
    check({tag, "_wave"}, badWave, 0);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int from, bad, t, r;

    // Reset with the FIFO empty, then 100 quiet cycles.
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    check("rst_txA", txA, 1);
    check("rst_rdA", fa.fifoRdEn, 0);
    check("rst_busyA", busyA, 0);
    check("rst_doneA", doneA, 0);
    check("rst_txB", txB, 1);
    check("rst_busyB", busyB, 0);
    bad = 0;
    repeat (100) begin
      tick();
      if (txA !== 1'b1 || fa.fifoRdEn !== 1'b0 || busyA !== 1'b0 || doneA !== 1'b0 ||
          txB !== 1'b1 || fb.fifoRdEn !== 1'b0 || busyB !== 1'b0 || doneB !== 1'b0) bad++;
    end
    check("rst_idle_stable", bad, 0);

    // Single byte.
    clearLogs();
    from = cyc;
    push(0, 8'h55);
    waitIdle("single");
    analyze(0, 1, from, "single");

    // Back-to-back bytes.
    clearLogs();
    from = cyc;
    push(0, 8'h00);
    push(0, 8'hFF);
    push(0, 8'hA5);
    waitIdle("b2b");
    analyze(0, 1, from, "b2b");
    if (startQ.size() == 3) begin
      check("b2b_space01", startQ[1] - startQ[0], 42);
      check("b2b_space12", startQ[2] - startQ[1], 42);
    end else begin
      check("b2b_starts", startQ.size(), 3);
    end

    // Two stop bits.
    clearLogs();
    from = cyc;
    push(1, 8'h80);
    waitIdle("stop2");
    analyze(1, 2, from, "stop2");

    // Reset during data bit 3 of 0x3C.
    clearLogs();
    push(0, 8'h3C);
    t = 0;
    while (rdCyc[0].size() == 0 && t < 200) begin
      tick();
      t++;
    end
    check("abort_rd_seen", rdCyc[0].size(), 1);
    r = (rdCyc[0].size() > 0) ? rdCyc[0][0] : cyc;
    while (cyc < r + 19) tick();
    rst = 1'b1;
    tick();
    check("abort_tx_high", txA, 1);
    check("abort_busy_low", busyA, 0);
    rst = 1'b0;
    repeat (60) tick();
    check("abort_no_done", doneCyc[0].size(), 0);
    clearLogs();
    from = cyc;
    push(0, 8'h81);
    waitIdle("abortnext");
    analyze(0, 1, from, "abortnext");

    // Empty flag toggled during a frame, then held high with data waiting.
    clearLogs();
    from = cyc;
    push(0, 8'h5A);
    t = 0;
    while (rdCyc[0].size() == 0 && t < 200) begin
      tick();
      t++;
    end
    repeat (10) tick();
    forceA = 1'b1;
    repeat (5) tick();
    forceA = 1'b0;
    repeat (5) tick();
    forceA = 1'b1;
    push(0, 8'h77);
    repeat (80) tick();
    check("empty_busy_low", busyA, 0);
    check("empty_rd_count", rdCyc[0].size(), 1);
    check("empty_byte_held", fifoQ[0].size(), 1);
    forceA = 1'b0;
    waitIdle("empty");
    analyze(0, 1, from, "empty");

    // Random bytes at random spacing into both transmitters.
    clearLogs();
    from = cyc;
    for (int j = 0; j < 16; j++) begin
      if ($urandom_range(0, 1) == 1) push(0, 8'($urandom));
      if ($urandom_range(0, 1) == 1) push(1, 8'($urandom));
      repeat ($urandom_range(0, 70)) tick();
    end
    waitIdle("rnd");
    analyze(0, 1, from, "rndA");
    analyze(1, 2, from, "rndB");

    check("rd_while_empty", badRd, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
